// File: rtl/dice_roll_controller.sv
// Roll sequencer for the dice roller: button synchronizer, free-running LFSR,
// spin animation, rejection-sampled reduction to a face value, and result hold.
module dice_roll_controller #(
    parameter int ROLL_CYCLES = 1024,
    parameter int ANIM_DIV    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_btn,
    input  logic [7:0] dip_switch,
    output logic [6:0] disp_value,
    output logic [1:0] disp_mode,
    output logic [6:0] result,
    output logic       result_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] ROLL_LAST = 16'(ROLL_CYCLES - 1);
    localparam logic [15:0] ANIM_LAST = 16'(ANIM_DIV - 1);

    localparam logic [1:0] MODE_BLANK  = 2'd0;
    localparam logic [1:0] MODE_SPIN   = 2'd1;
    localparam logic [1:0] MODE_RESULT = 2'd2;

    state_t      state;
    logic        btn_sync1;
    logic        btn_sync2;
    logic        btn_prev;
    logic        press;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] roll_cnt;
    logic [15:0] anim_cnt;
    logic [6:0]  die_n;
    logic [8:0]  die_limit;
    logic [7:0]  sample;
    logic [6:0]  sel_n;
    logic [8:0]  sel_limit;
    logic [6:0]  spin_digit;
    logic        dip_unused;

    assign dip_unused = ^dip_switch[7:3];
    assign press      = btn_sync2 & ~btn_prev;
    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    assign spin_digit = {3'b000, lfsr[3:0]} + 7'd1;

    // Limit is the largest multiple of N not above 256, so samples below it
    // reduce to a uniform face value.
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        sel_n     = 7'd4;
        sel_limit = 9'd256;
        case (dip_switch[2:0])
            3'd0: begin sel_n = 7'd4;   sel_limit = 9'd256; end
            3'd1: begin sel_n = 7'd6;   sel_limit = 9'd252; end
            3'd2: begin sel_n = 7'd8;   sel_limit = 9'd256; end
            3'd3: begin sel_n = 7'd10;  sel_limit = 9'd250; end
            3'd4: begin sel_n = 7'd12;  sel_limit = 9'd252; end
            3'd5: begin sel_n = 7'd20;  sel_limit = 9'd240; end
            3'd6: begin sel_n = 7'd100; sel_limit = 9'd200; end
            3'd7: begin sel_n = 7'd2;   sel_limit = 9'd256; end
            default: begin sel_n = 7'd4; sel_limit = 9'd256; end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            btn_sync1    <= 1'b0;
            btn_sync2    <= 1'b0;
            btn_prev     <= 1'b0;
            lfsr         <= LFSR_SEED;
            roll_cnt     <= 16'd0;
            anim_cnt     <= 16'd0;
            die_n        <= 7'd4;
            die_limit    <= 9'd256;
            sample       <= 8'd0;
            disp_value   <= 7'd0;
            disp_mode    <= MODE_BLANK;
            result       <= 7'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            btn_sync1 <= roll_btn;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
            lfsr      <= lfsr_next;

            case (state)
                IDLE, DONE: begin
                    if (press) begin
                        die_n        <= sel_n;
                        die_limit    <= sel_limit;
                        roll_cnt     <= 16'd0;
                        anim_cnt     <= 16'd0;
                        disp_value   <= spin_digit;
                        disp_mode    <= MODE_SPIN;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        state        <= ROLL;
                    end
                end

                ROLL: begin
                    if (roll_cnt == ROLL_LAST) begin
                        sample <= lfsr[7:0];
                        state  <= REDUCE;
                    end else begin
                        roll_cnt <= roll_cnt + 16'd1;
                        // The digit shown in ROLL cycle 0 was loaded on the press edge.
                        if (anim_cnt == ANIM_LAST) begin
                            anim_cnt   <= 16'd0;
                            disp_value <= spin_digit;
                        end else begin
                            anim_cnt <= anim_cnt + 16'd1;
                        end
                    end
                end

                REDUCE: begin
                    if ({1'b0, sample} >= die_limit) begin
                        sample <= lfsr[7:0];
                    end else if (sample >= {1'b0, die_n}) begin
                        sample <= sample - {1'b0, die_n};
                    end else begin
                        result       <= sample[6:0] + 7'd1;
                        disp_value   <= sample[6:0] + 7'd1;
                        disp_mode    <= MODE_RESULT;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
